// File: rtl/picorv32_axi_mem_pkg.sv
// picorv32_axi_mem_pkg: shared state encodings, fill constant and address-window helper
package picorv32_axi_mem_pkg;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  localparam logic [31:0] OOB_FILL = 32'hDEAD_BEEF;
  localparam int LAT_CNT_W = 4;
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction
endpackage

// File: rtl/picorv32_axi_mem_array.sv
// picorv32_axi_mem_array: byte-enabled word RAM with one write port and one registered read port
module picorv32_axi_mem_array #(
  parameter int WORDS = 4096,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [WORDS];
  always_ff @(posedge clk)
    if (we_i)
      for (int b = 0; b < 4; b++)
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  // Nonblocking read of mem_q returns the pre-write word on a same-edge collision.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/picorv32_axi_mem_slave.sv
// picorv32_axi_mem_slave: PicoRV32 AXI-lite memory slave with independent write/read FSMs,
// configurable read latency and a sticky out-of-window error flag.
module picorv32_axi_mem_slave
  import picorv32_axi_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int MEM_WORDS = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        oob_err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic r_oob_q, r_oob_d, oob_q, oob_d, live_q;
  logic aw_fire, w_fire, ar_fire, commit, w_in, r_in, rd_en;
  logic [31:0] wa, wd, ra, w_off, r_off, mem_rdata;
  logic [3:0] ws;
  logic unused_ok;

  // live_q keeps the readies low while in reset and for the edge that releases it.
  assign mem_axi_awready = live_q && w_state_q == W_IDLE && !aw_got_q;
  assign mem_axi_wready  = live_q && w_state_q == W_IDLE && !w_got_q;
  assign mem_axi_bvalid  = w_state_q == W_RESP;
  assign mem_axi_arready = live_q && r_state_q == R_IDLE;
  assign mem_axi_rvalid  = r_state_q == R_DATA;
  assign mem_axi_rdata   = r_oob_q ? OOB_FILL : mem_rdata;
  assign oob_err         = oob_q;

  assign aw_fire = mem_axi_awvalid && mem_axi_awready;
  assign w_fire  = mem_axi_wvalid && mem_axi_wready;
  assign ar_fire = mem_axi_arvalid && mem_axi_arready;
  assign wa = aw_got_q ? awaddr_q : mem_axi_awaddr;
  assign wd = w_got_q ? wdata_q : mem_axi_wdata;
  assign ws = w_got_q ? wstrb_q : mem_axi_wstrb;
  assign commit = (aw_got_q || aw_fire) && (w_got_q || w_fire);
  assign w_in = in_window(wa, BASE_ADDR, WIN_BYTES);
  assign w_off = wa - BASE_ADDR;
  assign ra = r_state_q == R_IDLE ? mem_axi_araddr : araddr_q;
  assign r_in = in_window(mem_axi_araddr, BASE_ADDR, WIN_BYTES);
  assign r_off = ra - BASE_ADDR;
  assign rd_en = (ar_fire && READ_LATENCY == 1) || (r_state_q == R_WAIT && cnt_q == '0);
  assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot, w_off[31:AW+2], w_off[1:0], r_off[31:AW+2], r_off[1:0]};

  always_comb begin
    w_state_d = commit ? W_RESP : (mem_axi_bvalid && mem_axi_bready) ? W_IDLE : w_state_q;
    aw_got_d  = !commit && (aw_got_q || aw_fire);
    w_got_d   = !commit && (w_got_q || w_fire);
    awaddr_d  = aw_fire ? mem_axi_awaddr : awaddr_q;
    wdata_d   = w_fire ? mem_axi_wdata : wdata_q;
    wstrb_d   = w_fire ? mem_axi_wstrb : wstrb_q;
    r_state_d = ar_fire ? (READ_LATENCY == 1 ? R_DATA : R_WAIT)
              : (r_state_q == R_WAIT && cnt_q == '0) ? R_DATA
              : (mem_axi_rvalid && mem_axi_rready) ? R_IDLE : r_state_q;
    cnt_d     = ar_fire ? LAT_INIT : (r_state_q == R_WAIT && cnt_q != '0) ? cnt_q - LAT_CNT_W'(1) : cnt_q;
    araddr_d  = ar_fire ? mem_axi_araddr : araddr_q;
    r_oob_d   = ar_fire ? !r_in : r_oob_q;
    oob_d     = oob_q || (commit && !w_in) || (ar_fire && !r_in);
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      cnt_q     <= '0;
      r_oob_q   <= 1'b0;
      oob_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      cnt_q     <= cnt_d;
      r_oob_q   <= r_oob_d;
      oob_q     <= oob_d;
      live_q    <= 1'b1;
    end

  picorv32_axi_mem_array #(.WORDS(MEM_WORDS), .AW(AW)) u_array (
    .clk(clk),
    .resetn(resetn),
    .we_i(commit && w_in),
    .waddr_i(w_off[AW+1:2]),
    .wdata_i(wd),
    .wstrb_i(ws),
    .re_i(rd_en),
    .raddr_i(r_off[AW+1:2]),
    .rdata_o(mem_rdata)
  );
endmodule
